// File: rtl/bus_read_arbiter.sv
// bus_read_arbiter
// Read-channel arbiter for two AXI3 read masters (m0, m1) sharing one slave port.
// It drives the m0_grnt/m1_grnt selects of the downstream read mux. A grant is held
// for one whole transaction: the AR handshake, then every R beat through rlast. The
// block also checks the R beat count against the latched arlen.
//
// Optional feature: define ROUND_ROBIN_EN to alternate grants on a simultaneous
// request. Without it, m0 always wins a simultaneous request.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   m0_arvalid, m0_arlen       master0 read-address request and burst length
//   m1_arvalid, m1_arlen       master1 read-address request and burst length
//   arvalid, arready           shared AR handshake (mux output / slave)
//   rvalid, rready, rlast      shared R handshake and last-beat flag
//   m0_grnt, m1_grnt           registered grants, never both high
//   busy                       a grant is held
//   burst_err                  sticky beat-count violation flag
module bus_read_arbiter #(
  parameter int unsigned ARLEN_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_arvalid,
  input  logic [ARLEN_W-1:0] m0_arlen,
  input  logic               m1_arvalid,
  input  logic [ARLEN_W-1:0] m1_arlen,
  input  logic               arvalid,
  input  logic               arready,
  input  logic               rvalid,
  input  logic               rready,
  input  logic               rlast,
  output logic               m0_grnt,
  output logic               m1_grnt,
  output logic               busy,
  output logic               burst_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e             state_q, state_d;
  logic               m0_grnt_q, m0_grnt_d;
  logic               m1_grnt_q, m1_grnt_d;
  logic               last_grnt_q, last_grnt_d;  // 0 = m0 granted last, 1 = m1
  logic               burst_err_q, burst_err_d;
  logic [ARLEN_W-1:0] len_q, len_d;
  logic [ARLEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic               beat;
  logic               pick_m1;

  assign beat = rvalid & rready;

`ifdef ROUND_ROBIN_EN
  // On contention hand the bus to whichever master did not win last time.
  assign pick_m1 = m1_arvalid & (~m0_arvalid | ~last_grnt_q);
`else
  assign pick_m1 = m1_arvalid & ~m0_arvalid;
`endif

  always_comb begin
    state_d     = state_q;
    m0_grnt_d   = m0_grnt_q;
    m1_grnt_d   = m1_grnt_q;
    last_grnt_d = last_grnt_q;
    burst_err_d = burst_err_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;

    unique case (state_q)
      StIdle: begin
        // Stray beats with no transaction open are a protocol violation.
        if (beat) burst_err_d = 1'b1;
        if (m0_arvalid | m1_arvalid) begin
          m0_grnt_d   = ~pick_m1;
          m1_grnt_d   = pick_m1;
          last_grnt_d = pick_m1;
          state_d     = StAddr;
        end
      end
      StAddr: begin
        if (beat) burst_err_d = 1'b1;
        if (arvalid & arready) begin
          len_d      = m1_grnt_q ? m1_arlen : m0_arlen;
          beat_cnt_d = '0;
          state_d    = StData;
        end
      end
      StData: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + ARLEN_W'(1);
          // rlast must coincide exactly with the beat whose index equals len_q:
          // an early rlast or a missing one (overrun) both flag the error.
          if (rlast != (beat_cnt_q == len_q)) burst_err_d = 1'b1;
          // The FSM always follows rlast so an error never stalls the bus.
          if (rlast) begin
            m0_grnt_d = 1'b0;
            m1_grnt_d = 1'b0;
            state_d   = StIdle;
          end
        end
      end
      default: begin
        m0_grnt_d = 1'b0;
        m1_grnt_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      m0_grnt_q   <= 1'b0;
      m1_grnt_q   <= 1'b0;
      last_grnt_q <= 1'b1;
      burst_err_q <= 1'b0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      m0_grnt_q   <= m0_grnt_d;
      m1_grnt_q   <= m1_grnt_d;
      last_grnt_q <= last_grnt_d;
      burst_err_q <= burst_err_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign m0_grnt   = m0_grnt_q;
  assign m1_grnt   = m1_grnt_q;
  assign busy      = m0_grnt_q | m1_grnt_q;
  assign burst_err = burst_err_q;

endmodule

// File: tb/tb_bus_read_arbiter.sv
// Self-checking bench for bus_read_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level reference model.
module tb_bus_read_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_arvalid, m1_arvalid;
  logic [3:0] m0_arlen, m1_arlen;
  logic       arvalid, arready, rvalid, rready, rlast;
  logic       m0_grnt, m1_grnt, busy, burst_err;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  bus_read_arbiter #(.ARLEN_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_arvalid (m0_arvalid),
    .m0_arlen   (m0_arlen),
    .m1_arvalid (m1_arvalid),
    .m1_arlen   (m1_arlen),
    .arvalid    (arvalid),
    .arready    (arready),
    .rvalid     (rvalid),
    .rready     (rready),
    .rlast      (rlast),
    .m0_grnt    (m0_grnt),
    .m1_grnt    (m1_grnt),
    .busy       (busy),
    .burst_err  (burst_err)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, whether the address phase is done,
  // how many beats have arrived and how many were promised.
  int mdl_owner;     // 0 none, 1 m0, 2 m1
  bit mdl_in_data;
  int mdl_len;
  int mdl_beats;
  bit mdl_err;
  int mdl_last;      // 0 m0, 1 m1
  bit mdl_beat;

  always @(posedge clk) begin
    mdl_beat = rvalid && rready;
    if (rst) begin
      mdl_owner = 0; mdl_in_data = 0; mdl_len = 0; mdl_beats = 0;
      mdl_err = 0; mdl_last = 1;
    end else if (mdl_owner == 0) begin
      if (mdl_beat) mdl_err = 1;
      if (m0_arvalid || m1_arvalid) begin
`ifdef ROUND_ROBIN_EN
        if (m0_arvalid && m1_arvalid) mdl_owner = (mdl_last == 1) ? 1 : 2;
        else mdl_owner = m0_arvalid ? 1 : 2;
`else
        mdl_owner = m0_arvalid ? 1 : 2;
`endif
        mdl_last = mdl_owner - 1;
      end
    end else if (!mdl_in_data) begin
      if (mdl_beat) mdl_err = 1;
      if (arvalid && arready) begin
        mdl_len     = (mdl_owner == 1) ? int'(m0_arlen) : int'(m1_arlen);
        mdl_beats   = 0;
        mdl_in_data = 1;
      end
    end else if (mdl_beat) begin
      // Beat counter is 4 bits wide, so compare modulo 16.
      if (rlast != ((mdl_beats % 16) == mdl_len)) mdl_err = 1;
      mdl_beats++;
      if (rlast) begin
        mdl_owner   = 0;
        mdl_in_data = 0;
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model m0_grnt", int'(m0_grnt), int'(mdl_owner == 1));
      check("model m1_grnt", int'(m1_grnt), int'(mdl_owner == 2));
      check("model busy", int'(busy), int'(mdl_owner != 0));
      check("model burst_err", int'(burst_err), int'(mdl_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_arvalid = 0; m1_arvalid = 0; m0_arlen = 0; m1_arlen = 0;
    arvalid = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic beat(input bit last);
    rvalid = 1; rready = 1; rlast = last;
    step();
    rvalid = 0; rready = 0; rlast = 0;
  endtask

  task automatic addr_hs();
    arvalid = 1; arready = 1;
    step();
    arvalid = 0; arready = 0;
  endtask

  int exp_seq[3];
  int got_who;

  initial begin
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    chk_en = 1;
    check("reset m0_grnt", int'(m0_grnt), 0);
    check("reset m1_grnt", int'(m1_grnt), 0);
    check("reset busy", int'(busy), 0);
    check("reset burst_err", int'(burst_err), 0);

    // 1: m0 single burst of 4 beats with rlast on the 4th.
    m0_arvalid = 1; m0_arlen = 4'd3;
    step();
    check("t1 grant", int'(m0_grnt), 1);
    m0_arvalid = 0;
    step();
    check("t1 addr wait", int'(m0_grnt), 1);
    addr_hs();
    for (int i = 0; i < 3; i++) begin
      beat(0);
      check("t1 grant mid", int'(m0_grnt), 1);
    end
    beat(1);
    check("t1 grant drop", int'(busy), 0);
    check("t1 burst_err", int'(burst_err), 0);
    check("t1 model err", int'(mdl_err), 0);

    // 2: both requesting continuously, single-beat bursts.
    do_reset();
`ifdef ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0};
`else
    exp_seq = '{0, 0, 0};
`endif
    m0_arvalid = 1; m1_arvalid = 1;
    for (int t = 0; t < 3; t++) begin
      step();
      got_who = m0_grnt ? 0 : (m1_grnt ? 1 : 2);
      check("t2 contention winner", got_who, exp_seq[t]);
      addr_hs();
      beat(1);
      check("t2 idle gap", int'(busy), 0);
    end
    check("t2 burst_err", int'(burst_err), 0);

    // 3: m1, arlen=3, rlast early on 2nd beat.
    do_reset();
    m1_arvalid = 1; m1_arlen = 4'd3;
    step();
    check("t3 m1 grant", int'(m1_grnt), 1);
    m1_arvalid = 0;
    addr_hs();
    beat(0);
    beat(1);
    check("t3 burst_err", int'(burst_err), 1);
    check("t3 idle", int'(busy), 0);
    step(); step();
    check("t3 sticky", int'(burst_err), 1);
    check("t3 model err", int'(mdl_err), 1);

    // 4: arlen=1 but no rlast until the 4th beat.
    do_reset();
    m0_arvalid = 1; m0_arlen = 4'd1;
    step();
    m0_arvalid = 0;
    addr_hs();
    beat(0); beat(0); beat(0);
    check("t4 overrun err", int'(burst_err), 1);
    check("t4 grant held", int'(m0_grnt), 1);
    beat(1);
    check("t4 grant drop", int'(m0_grnt), 0);

    // 5: stray beat in ADDR, then reset in DATA after 2 of 8 beats.
    do_reset();
    m0_arvalid = 1; m0_arlen = 4'd7;
    step();
    m0_arvalid = 0;
    beat(0);
    check("t5 stray beat err", int'(burst_err), 1);
    addr_hs();
    beat(0); beat(0);
    rst = 1;
    step();
    rst = 0;
    check("t5 rst m0_grnt", int'(m0_grnt), 0);
    check("t5 rst busy", int'(busy), 0);
    check("t5 rst burst_err", int'(burst_err), 0);
    m1_arvalid = 1;
    step();
    check("t5 idle after rst", int'(m1_grnt), 1);

    // 6: m0 in ADDR drops its request while m1 requests.
    do_reset();
    m0_arvalid = 1;
    step();
    m0_arvalid = 0; m1_arvalid = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6 m0 held", int'(m0_grnt), 1);
      check("t6 m1 blocked", int'(m1_grnt), 0);
    end
    m1_arvalid = 0;
    addr_hs();
    beat(1);
    check("t6 done", int'(busy), 0);
    check("t6 model owner", mdl_owner, 0);

    // Randomized traffic; the compare process checks every cycle.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      m0_arvalid = ($urandom_range(0, 2) != 0);
      m1_arvalid = ($urandom_range(0, 2) != 0);
      m0_arlen   = 4'($urandom_range(0, 3));
      m1_arlen   = 4'($urandom_range(0, 3));
      arvalid    = (mdl_owner == 1) ? m0_arvalid : ((mdl_owner == 2) ? m1_arvalid : 1'b0);
      arready    = 1'($urandom_range(0, 1));
      if (mdl_in_data) begin
        rvalid = 1'($urandom_range(0, 1));
        rready = ($urandom_range(0, 3) != 0);
        rlast  = ((mdl_beats % 16) == mdl_len);
        if ($urandom_range(0, 15) == 0) rlast = ~rlast;
      end else begin
        rvalid = ($urandom_range(0, 40) == 0);
        rready = 1;
        rlast  = 1'($urandom_range(0, 1));
      end
      step();
    end
    rst = 0;
    clear_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
